// File: rtl/bnn_ctrl_pkg.sv
// rtl/bnn_ctrl_pkg.sv - opcodes, FSM encoding and instruction field slices for bnn_ctrl_seq
package bnn_ctrl_pkg;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_LDI  = 5'h01;
    localparam logic [4:0] OP_LSH  = 5'h02;
    localparam logic [4:0] OP_ADDI = 5'h03;
    localparam logic [4:0] OP_CMP  = 5'h04;
    localparam logic [4:0] OP_BR   = 5'h05;
    localparam logic [4:0] OP_CHI  = 5'h06;
    localparam logic [4:0] OP_CORE = 5'h07;
    localparam logic [4:0] OP_MEMR = 5'h08;
    localparam logic [4:0] OP_MEMW = 5'h09;
    localparam logic [4:0] OP_LOOP = 5'h0A;
    localparam logic [4:0] OP_ENDL = 5'h0B;
    localparam logic [4:0] OP_HALT = 5'h0C;

    localparam int OP_MSB     = 15;
    localparam int OP_LSB     = 11;
    localparam int RD_MSB     = 10;
    localparam int RD_LSB     = 7;
    localparam int IMM7_MSB   = 6;
    localparam int IMM7_LSB   = 0;
    localparam int LOOP_CNT_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_EXEC  = 2'd3
    } state_t;

endpackage

// File: rtl/bnn_loop_stack.sv
// rtl/bnn_loop_stack.sv - hardware loop stack of {start pc, remaining count} entries
module bnn_loop_stack #(
    parameter int DEPTH = 4,
    parameter int AW    = 11,
    parameter int CW    = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic          dec,
    input  logic [AW-1:0] push_start,
    input  logic [CW-1:0] push_cnt,
    output logic [AW-1:0] top_start,
    output logic [CW-1:0] top_cnt,
    output logic          full,
    output logic          empty
);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SPW = $clog2(DEPTH + 1);

    logic [AW-1:0]  r_start [DEPTH];
    logic [CW-1:0]  r_cnt   [DEPTH];
    logic [SPW-1:0] r_sp;
    logic [IW-1:0]  w_top_idx;
    logic [IW-1:0]  w_push_idx;

    assign w_top_idx  = IW'(r_sp - 1'b1);
    assign w_push_idx = IW'(r_sp);
    assign full       = (r_sp == SPW'(DEPTH));
    assign empty      = (r_sp == '0);
    assign top_start  = r_start[w_top_idx];
    assign top_cnt    = r_cnt[w_top_idx];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_start[i] <= '0;
                r_cnt[i]   <= '0;
            end
        end else if (push && !full) begin
            r_start[w_push_idx] <= push_start;
            r_cnt[w_push_idx]   <= push_cnt;
            r_sp                <= r_sp + 1'b1;
        end else if (pop && !empty) begin
            r_sp <= r_sp - 1'b1;
        end else if (dec && !empty) begin
            r_cnt[w_top_idx] <= r_cnt[w_top_idx] - 1'b1;
        end
    end

endmodule

// File: rtl/bnn_ctrl_seq.sv
// rtl/bnn_ctrl_seq.sv - BNN accelerator instruction sequencer with loop stack and branches
module bnn_ctrl_seq
    import bnn_ctrl_pkg::*;
#(
    parameter int INST_W     = 16,
    parameter int IADDR_W    = 11,
    parameter int DADDR_W    = 13,
    parameter int REG_W      = 16,
    parameter int NREG       = 16,
    parameter int CORE_W     = 20,
    parameter int LOOP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IADDR_W-1:0] start_pc,
    input  logic               pause,
    input  logic [INST_W-1:0]  inst_rdata,
    output logic [IADDR_W-1:0] inst_addr,
    output logic               inst_cen,
    output logic [CORE_W-1:0]  core_ctrl,
    output logic [DADDR_W-1:0] data_addr,
    output logic               data_cen,
    output logic               data_wen,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int HI_W = CORE_W - 11;

    state_t              r_state;
    logic [IADDR_W-1:0]  r_pc;
    logic [INST_W-1:0]   r_ir;
    logic [REG_W-1:0]    r_regs [NREG];
    logic                r_flag;
    logic [HI_W-1:0]     r_ctrl_hi;
    logic [IADDR_W-1:0]  r_inst_addr;
    logic                r_inst_cen;
    logic [CORE_W-1:0]   r_core_ctrl;
    logic [DADDR_W-1:0]  r_data_addr;
    logic                r_data_cen;
    logic                r_data_wen;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic [4:0]            w_op;
    logic [3:0]            w_rd;
    logic [6:0]            w_imm7;
    logic [REG_W-1:0]      w_rd_val;
    logic [REG_W-1:0]      w_sext7;
    logic [IADDR_W-1:0]    w_pc_inc;
    logic [IADDR_W-1:0]    w_br_off;
    logic [IADDR_W-1:0]    w_next_pc;
    logic [LOOP_CNT_W-1:0] w_loop_cnt;
    logic [IADDR_W-1:0]    w_top_start;
    logic [LOOP_CNT_W-1:0] w_top_cnt;
    logic                  w_ls_full;
    logic                  w_ls_empty;
    logic                  w_exec;
    logic                  w_err;
    logic                  w_wr_en;
    logic [REG_W-1:0]      w_wr_data;

    assign w_op       = r_ir[OP_MSB:OP_LSB];
    assign w_rd       = r_ir[RD_MSB:RD_LSB];
    assign w_imm7     = r_ir[IMM7_MSB:IMM7_LSB];
    assign w_rd_val   = (w_rd == 4'd0) ? '0 : r_regs[w_rd];
    assign w_sext7    = {{(REG_W-7){w_imm7[6]}}, w_imm7};
    assign w_pc_inc   = r_pc + 1'b1;
    assign w_br_off   = {{(IADDR_W-10){r_ir[9]}}, r_ir[9:0]};
    assign w_loop_cnt = (r_ir[10:0] == 11'd0) ? 11'd1 : r_ir[10:0];
    assign w_exec     = (r_state == ST_EXEC) && !pause;

    // Stack over/underflow and the reserved upper opcode half abort the program.
    assign w_err = ((w_op == OP_LOOP) && w_ls_full) ||
                   ((w_op == OP_ENDL) && w_ls_empty) ||
                   r_ir[OP_MSB];

    always_comb begin
        w_next_pc = w_pc_inc;
        if ((w_op == OP_BR) && (!r_ir[10] || r_flag))
            w_next_pc = r_pc + w_br_off;
        else if ((w_op == OP_ENDL) && (w_top_cnt > 11'd1))
            w_next_pc = w_top_start;
    end

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = w_rd_val;
        case (w_op)
            OP_LDI:  begin w_wr_en = 1'b1; w_wr_data = w_sext7; end
            OP_LSH:  begin w_wr_en = 1'b1; w_wr_data = {w_rd_val[REG_W-8:0], w_imm7}; end
            OP_ADDI: begin w_wr_en = 1'b1; w_wr_data = w_rd_val + w_sext7; end
            OP_MEMR, OP_MEMW: begin
                w_wr_en   = r_ir[6];
                w_wr_data = r_ir[5] ? (w_rd_val + 1'b1) : (w_rd_val - 1'b1);
            end
            default: ;
        endcase
    end

    bnn_loop_stack #(
        .DEPTH (LOOP_DEPTH),
        .AW    (IADDR_W),
        .CW    (LOOP_CNT_W)
    ) u_loop_stack (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_exec && ((w_op == OP_HALT) || w_err)),
        .push       (w_exec && (w_op == OP_LOOP)),
        .pop        (w_exec && (w_op == OP_ENDL) && (w_top_cnt <= 11'd1)),
        .dec        (w_exec && (w_op == OP_ENDL) && (w_top_cnt > 11'd1)),
        .push_start (w_pc_inc),
        .push_cnt   (w_loop_cnt),
        .top_start  (w_top_start),
        .top_cnt    (w_top_cnt),
        .full       (w_ls_full),
        .empty      (w_ls_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_ir        <= '0;
            r_flag      <= 1'b0;
            r_ctrl_hi   <= '0;
            r_inst_addr <= '0;
            r_inst_cen  <= 1'b1;
            r_core_ctrl <= '0;
            r_data_addr <= '0;
            r_data_cen  <= 1'b1;
            r_data_wen  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            r_core_ctrl <= '0;
            r_data_cen  <= 1'b1;
            r_data_wen  <= 1'b1;
            r_inst_cen  <= 1'b1;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_pc    <= start_pc;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= ST_FETCH;
                end
                ST_FETCH: if (!pause) begin
                    r_inst_addr <= r_pc;
                    r_inst_cen  <= 1'b0;
                    r_state     <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_ir    <= inst_rdata;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: if (!pause) begin
                    if (w_err) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_pc    <= w_next_pc;
                        r_state <= ST_FETCH;
                        if (w_wr_en && (w_rd != 4'd0)) r_regs[w_rd] <= w_wr_data;
                        case (w_op)
                            OP_NOP:  ;
                            OP_CMP:  r_flag <= (w_rd_val < {{(REG_W-7){1'b0}}, w_imm7});
                            OP_CHI:  r_ctrl_hi <= r_ir[CORE_W-12:0];
                            OP_CORE: r_core_ctrl <= {r_ctrl_hi, r_ir[10:0]};
                            OP_MEMR, OP_MEMW: begin
                                r_data_addr <= w_rd_val[DADDR_W-1:0];
                                r_data_cen  <= 1'b0;
                                r_data_wen  <= (w_op == OP_MEMR);
                                r_core_ctrl <= {r_ctrl_hi, 6'b0, r_ir[4:0]};
                            end
                            OP_HALT: begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign inst_addr = r_inst_addr;
    assign inst_cen  = r_inst_cen;
    assign core_ctrl = r_core_ctrl;
    assign data_addr = r_data_addr;
    assign data_cen  = r_data_cen;
    assign data_wen  = r_data_wen;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_bnn_ctrl_seq.sv
// tb/tb_bnn_ctrl_seq.sv - self-checking bench for bnn_ctrl_seq against an ISA-level reference model
module tb_bnn_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [10:0] start_pc = '0;
    logic [15:0] inst_rdata = '0;
    logic [10:0] inst_addr;
    logic        inst_cen;
    logic [19:0] core_ctrl;
    logic [12:0] data_addr;
    logic        data_cen;
    logic        data_wen;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:2047];
    logic [10:0] wp;

    int m_reg [16];
    int m_flag, m_chi, m_pc, cyc;
    int ls_start [$];
    int ls_cnt [$];
    int core_cyc [$];

    bnn_ctrl_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_pc   (start_pc),
        .pause      (pause),
        .inst_rdata (inst_rdata),
        .inst_addr  (inst_addr),
        .inst_cen   (inst_cen),
        .core_ctrl  (core_ctrl),
        .data_addr  (data_addr),
        .data_cen   (data_cen),
        .data_wen   (data_wen),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Instruction SRAM: read data appears within the cycle after a low chip enable.
    always @(negedge clk) if (!inst_cen) inst_rdata <= mem[inst_addr];

    function automatic logic [15:0] ins(input int op, input int rd, input int imm);
        return {op[4:0], rd[3:0], imm[6:0]};
    endfunction

    function automatic logic [15:0] ins11(input int op, input int v);
        return {op[4:0], v[10:0]};
    endfunction

    task automatic put(input logic [15:0] w);
        mem[wp] = w;
        wp = wp + 11'd1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 0;
        m_flag = 0;
        m_chi  = 0;
        ls_start.delete();
        ls_cnt.delete();
    endtask

    task automatic model_step(input logic [15:0] inst, output int e_core, output int e_dcen,
                              output int e_dwen, output int e_daddr, output int e_done,
                              output int e_err, output int e_stop);
        int op, rd, imm, simm, rv, nxt, off, wv, wr;
        op = int'(inst[15:11]);
        rd = int'(inst[10:7]);
        imm = int'(inst[6:0]);
        simm = (imm >= 64) ? imm - 128 : imm;
        rv = m_reg[rd];
        nxt = (m_pc + 1) % 2048;
        wr = 0; wv = 0;
        e_core = 0; e_dcen = 1; e_dwen = 1; e_daddr = 0; e_done = 0; e_err = 0; e_stop = 0;
        case (op)
            1: begin wr = 1; wv = (simm + 65536) % 65536; end
            2: begin wr = 1; wv = (rv * 128 + imm) % 65536; end
            3: begin wr = 1; wv = (rv + simm + 65536) % 65536; end
            4: m_flag = (rv < imm) ? 1 : 0;
            5: if (inst[10] == 1'b0 || m_flag == 1) begin
                off = int'(inst[9:0]);
                if (off >= 512) off = off - 1024;
                nxt = ((m_pc + off) % 2048 + 2048) % 2048;
            end
            6: m_chi = int'(inst[8:0]);
            7: e_core = m_chi * 2048 + int'(inst[10:0]);
            8, 9: begin
                e_dcen = 0;
                e_dwen = (op == 8) ? 1 : 0;
                e_daddr = rv % 8192;
                e_core = m_chi * 2048 + int'(inst[4:0]);
                if (inst[6]) begin
                    wr = 1;
                    wv = inst[5] ? (rv + 1) % 65536 : (rv + 65535) % 65536;
                end
            end
            10: if (ls_cnt.size() == 4) e_err = 1;
                else begin
                    ls_start.push_back(nxt);
                    ls_cnt.push_back((inst[10:0] == 11'd0) ? 1 : int'(inst[10:0]));
                end
            11: if (ls_cnt.size() == 0) e_err = 1;
                else if (ls_cnt[ls_cnt.size()-1] > 1) begin
                    ls_cnt[ls_cnt.size()-1] = ls_cnt[ls_cnt.size()-1] - 1;
                    nxt = ls_start[ls_start.size()-1];
                end else begin
                    void'(ls_cnt.pop_back());
                    void'(ls_start.pop_back());
                end
            12: begin e_done = 1; e_stop = 1; end
            default: if (op >= 16) e_err = 1;
        endcase
        if (e_err == 1) begin e_stop = 1; nxt = m_pc; wr = 0; end
        if (e_stop == 1) begin ls_cnt.delete(); ls_start.delete(); end
        if (wr == 1 && rd != 0) m_reg[rd] = wv;
        m_pc = nxt;
    endtask

    task automatic run_prog(input string name, input logic [10:0] spc, input int pause_k,
                            input int pause_len, input int reset_k);
        int e_core, e_dcen, e_dwen, e_daddr, e_done, e_err, e_stop;
        core_cyc.delete();
        cyc = 0;
        m_pc = int'(spc);
        start = 1'b1;
        start_pc = spc;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
        n_checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start: busy=%b err=%b, required busy=1 err=0", name, busy, err);
        end
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1; cyc++;
            n_checks++;
            if (inst_cen !== 1'b0 || inst_addr !== m_pc[10:0]) begin
                n_fail++;
                $display("FAIL %s fetch[%0d]: inst_cen=%b inst_addr=%h, required 0 and %h",
                         name, k, inst_cen, inst_addr, m_pc[10:0]);
            end
            @(posedge clk); #1; cyc++;
            n_checks++;
            if (inst_cen !== 1'b1 || core_ctrl !== 20'h0 || data_cen !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s latch[%0d]: inst_cen=%b core=%h data_cen=%b busy=%b, required 1/0/1/1",
                         name, k, inst_cen, core_ctrl, data_cen, busy);
            end
            if (k == reset_k) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                model_reset();
                n_checks++;
                if (core_ctrl !== 20'h0 || data_addr !== 13'h0 || data_cen !== 1'b1 || data_wen !== 1'b1 ||
                    inst_cen !== 1'b1 || inst_addr !== 11'h0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s reset_mid: core=%h daddr=%h dcen=%b dwen=%b icen=%b iaddr=%h busy=%b done=%b err=%b, required 0/0/1/1/1/0/0/0/0",
                             name, core_ctrl, data_addr, data_cen, data_wen, inst_cen, inst_addr, busy, done, err);
                end
                return;
            end
            if (k == pause_k) begin
                pause = 1'b1;
                repeat (pause_len) begin
                    @(posedge clk); #1; cyc++;
                    n_checks++;
                    if (core_ctrl !== 20'h0 || data_cen !== 1'b1 || busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL %s pause[%0d]: core=%h data_cen=%b busy=%b, required 0/1/1",
                                 name, k, core_ctrl, data_cen, busy);
                    end
                end
                pause = 1'b0;
            end
            model_step(mem[m_pc], e_core, e_dcen, e_dwen, e_daddr, e_done, e_err, e_stop);
            @(posedge clk); #1; cyc++;
            if (core_ctrl !== 20'h0) core_cyc.push_back(cyc);
            n_checks++;
            if (core_ctrl !== e_core[19:0]) begin
                n_fail++;
                $display("FAIL %s exec[%0d] core_ctrl: got %h required %h", name, k, core_ctrl, e_core[19:0]);
            end
            n_checks++;
            if (data_cen !== e_dcen[0] || data_wen !== e_dwen[0]) begin
                n_fail++;
                $display("FAIL %s exec[%0d] data strobes: cen=%b wen=%b required %b %b",
                         name, k, data_cen, data_wen, e_dcen[0], e_dwen[0]);
            end
            if (e_dcen == 0) begin
                n_checks++;
                if (data_addr !== e_daddr[12:0]) begin
                    n_fail++;
                    $display("FAIL %s exec[%0d] data_addr: got %h required %h", name, k, data_addr, e_daddr[12:0]);
                end
            end
            n_checks++;
            if (done !== e_done[0] || err !== e_err[0] || busy !== (e_stop == 0)) begin
                n_fail++;
                $display("FAIL %s exec[%0d] status: done=%b err=%b busy=%b required %b %b %b",
                         name, k, done, err, busy, e_done[0], e_err[0], (e_stop == 0));
            end
            if (e_stop == 1) begin
                @(posedge clk); #1;
                n_checks++;
                if (done !== 1'b0 || busy !== 1'b0 || inst_cen !== 1'b1 || err !== e_err[0]) begin
                    n_fail++;
                    $display("FAIL %s after_stop: done=%b busy=%b inst_cen=%b err=%b required 0 0 1 %b",
                             name, done, busy, inst_cen, err, e_err[0]);
                end
                return;
            end
        end
        n_fail++;
        $display("FAIL %s budget: program did not stop within 300 instructions", name);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (core_ctrl !== 20'h0 || data_addr !== 13'h0 || data_cen !== 1'b1 || data_wen !== 1'b1 ||
            inst_cen !== 1'b1 || inst_addr !== 11'h0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: core=%h daddr=%h dcen=%b dwen=%b icen=%b iaddr=%h busy=%b done=%b err=%b, required 0/0/1/1/1/0/0/0/0",
                     core_ctrl, data_addr, data_cen, data_wen, inst_cen, inst_addr, busy, done, err);
        end
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_ldi_cmp_halt();
        wp = 11'd100;
        put(ins(1, 2, 3));
        put(ins(4, 2, 5));
        put(ins11(5, 1024 + 2));
        put(ins11(7, 'hAA));
        put(ins(8, 2, 0));
        put(ins(12, 0, 0));
        run_prog("ldi_cmp_halt", 11'd100, -1, 0, -1);
        n_checks++;
        if (core_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL ldi_cmp_branch: %0d core pulses, required 0 (flag set skips CORE)", core_cyc.size());
        end
    endtask

    task automatic test_loop();
        wp = 11'd200;
        put(ins11(6, 0));
        put(ins11(10, 4));
        put(ins11(7, 'h155));
        put(ins11(11, 0));
        put(ins(12, 0, 0));
        run_prog("loop4", 11'd200, -1, 0, -1);
        n_checks++;
        if (core_cyc.size() !== 4) begin
            n_fail++;
            $display("FAIL loop_count: %0d core pulses, required 4", core_cyc.size());
        end
        for (int i = 1; i < core_cyc.size(); i++) begin
            n_checks++;
            if (core_cyc[i] - core_cyc[i-1] !== 6) begin
                n_fail++;
                $display("FAIL loop_spacing: gap %0d, required 6", core_cyc[i] - core_cyc[i-1]);
            end
        end
        wp = 11'd300;
        put(ins11(11, 0));
        put(ins(12, 0, 0));
        run_prog("endl_empty", 11'd300, -1, 0, -1);
    endtask

    task automatic test_memw_postinc();
        wp = 11'd400;
        put(ins(1, 3, 10));
        put(ins(9, 3, 'h60));
        put(ins(9, 3, 'h60));
        put(ins(8, 3, 0));
        put(ins(12, 0, 0));
        run_prog("memw_postinc", 11'd400, -1, 0, -1);
    endtask

    task automatic test_pause();
        wp = 11'd500;
        put(ins11(6, 3));
        put(ins11(7, 'h155));
        put(ins(12, 0, 0));
        run_prog("pause_core", 11'd500, 1, 5, -1);
        n_checks++;
        if (core_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL pause_pulses: %0d core pulses, required 1", core_cyc.size());
        end
    endtask

    task automatic test_errors();
        wp = 11'd600;
        repeat (5) put(ins11(10, 1));
        put(ins(12, 0, 0));
        run_prog("loop_overflow", 11'd600, -1, 0, -1);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b done=%b busy=%b required 1 0 0", err, done, busy);
        end
        wp = 11'd700;
        put(ins(13, 0, 0));
        put(ins(12, 0, 0));
        run_prog("restart_clears_err", 11'd700, -1, 0, -1);
        wp = 11'd750;
        put(ins(19, 5, 9));
        put(ins(12, 0, 0));
        run_prog("undef_opcode", 11'd750, -1, 0, -1);
    endtask

    task automatic test_reset_mid();
        wp = 11'd800;
        put(ins(1, 4, 7));
        put(ins(8, 4, 0));
        put(ins(12, 0, 0));
        run_prog("reset_mid_memr", 11'd800, -1, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int n, r, rd;
        logic [10:0] base;
        for (int t = 0; t < 8; t++) begin
            base = 11'($urandom_range(0, 2047));
            wp = base;
            n = int'($urandom_range(4, 12));
            for (int i = 0; i < n; i++) begin
                r = int'($urandom_range(0, 11));
                rd = int'($urandom_range(0, 15));
                case (r)
                    0: put(ins(0, rd, int'($urandom_range(0, 127))));
                    1, 11: put(ins(1, rd, int'($urandom_range(0, 127))));
                    2: put(ins(2, rd, int'($urandom_range(0, 127))));
                    3: put(ins(3, rd, int'($urandom_range(0, 127))));
                    4: put(ins(4, rd, int'($urandom_range(0, 127))));
                    5: put(ins11(5, int'($urandom_range(0, 1)) * 1024 + int'($urandom_range(1, 3))));
                    6: put(ins11(6, int'($urandom_range(0, 2047))));
                    7: put(ins11(7, int'($urandom_range(0, 2047))));
                    8: put(ins(8, rd, int'($urandom_range(0, 127))));
                    9: put(ins(9, rd, int'($urandom_range(0, 127))));
                    default: put(ins(13 + int'($urandom_range(0, 2)), rd, int'($urandom_range(0, 127))));
                endcase
            end
            repeat (4) put(ins(12, 0, 0));
            run_prog("random", base, int'($urandom_range(0, n - 1)), int'($urandom_range(1, 3)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_ldi_cmp_halt();
        test_loop();
        test_memw_postinc();
        test_pause();
        test_errors();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
